// File: rtl/blinky_button_pio.sv
// Debounced button PIO with edge capture, interrupt mask and Avalon-MM regs.
// Ports: clk, reset (sync, active high), Avalon-MM slave
//   (address, chipselect, write_n, writedata, readdata), in_port, irq.
module blinky_button_pio #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_nx;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] clr;
  logic [CW-1:0]    cnt    [WIDTH];
  logic [CW-1:0]    cnt_nx [WIDTH];
  logic             wr_en;
  logic [31:0]      rd_nx;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  // A level is accepted only after sync2 disagrees with stable for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    stable_nx = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nx[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CMAX) begin
          stable_nx[i] = sync2[i];
        end else begin
          cnt_nx[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = stable_nx & ~stable;
  assign fall = ~stable_nx & stable;

  always_comb begin
    set = rise | fall;
    if (EDGE_TYPE == 0) begin
      set = rise;
    end else if (EDGE_TYPE == 1) begin
      set = fall;
    end
  end

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_nx = '0;
    unique case (address)
      2'd0: rd_nx = 32'(stable);
      2'd1: rd_nx = '0;
      2'd2: rd_nx = 32'(irqmask);
      2'd3: rd_nx = 32'(edgecapture);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      stable      <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
      readdata    <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= in_port;
      sync2  <= sync1;
      stable <= stable_nx;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nx[i];
      end
      // set after clear: a new edge beats a same-cycle acknowledge
      edgecapture <= (edgecapture & ~clr) | set;
      if (wr_en && address == 2'd2) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      readdata <= rd_nx;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_blinky_button_pio.sv
// Bench for blinky_button_pio: three instances (rising/falling/any edge)
// share one bus and input; readback is scored through a queue.
module tb_blinky_button_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [2:0]  in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  blinky_button_pio #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) d0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0),
    .in_port(in_port), .irq(irq0));
  blinky_button_pio #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) d1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1),
    .in_port(in_port), .irq(irq1));
  blinky_button_pio #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) d2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2),
    .in_port(in_port), .irq(irq2));

  typedef struct {
    string       nm;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   ncmp = 0;
  int   nbad = 0;

  task automatic issue(input logic [1:0] a, input logic [31:0] x0,
                       input logic [31:0] x1, input logic [31:0] x2,
                       input string nm);
    @(negedge clk);
    address = a;
    sb.push_back('{nm, x0, x1, x2});
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = '0;
    repeat (3) @(posedge clk);
    #1;
    ncmp++;
    if ({irq0, irq1, irq2} !== 3'b000) begin
      nbad++;
      $display("FAIL rst_irq: got %b want 000", {irq0, irq1, irq2});
    end
    for (int a = 0; a < 4; a++) begin
      issue(2'(a), 0, 0, 0, $sformatf("rst_addr%0d", a));
      e = sb.pop_front();
      ncmp++;
      if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
        nbad++;
        $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
                 e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_debounce;
    @(negedge clk);
    in_port[0] = 1'b1;
    address    = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      logic [31:0] v;
      v = (k == 7) ? 32'd1 : 32'd0;
      sb.push_back('{$sformatf("deb_edge%0d", k), v, v, v});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      ncmp++;
      if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
        nbad++;
        $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
                 e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
      end
    end
    issue(2'd3, 1, 0, 1, "deb_ec");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    ncmp++;
    if ({irq0, irq1, irq2} !== 3'b000) begin
      nbad++;
      $display("FAIL deb_irq_nomask: got %b want 000", {irq0, irq1, irq2});
    end
  endtask

  task automatic test_glitch;
    wr(2'd3, 32'h7);
    @(negedge clk);
    in_port[1] = 1'b1;
    repeat (3) @(negedge clk);
    in_port[1] = 1'b0;
    wait_cyc(10);
    issue(2'd0, 1, 1, 1, "glitch_stable");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    issue(2'd3, 0, 0, 0, "glitch_ec");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    ncmp++;
    if ({irq0, irq1, irq2} !== 3'b000) begin
      nbad++;
      $display("FAIL glitch_irq: got %b want 000", {irq0, irq1, irq2});
    end
  endtask

  task automatic test_irq;
    @(negedge clk);
    in_port[0] = 1'b0;
    wait_cyc(10);
    wr(2'd3, 32'h7);
    wr(2'd2, 32'h1);
    issue(2'd2, 1, 1, 1, "irq_mask");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    ncmp++;
    if ({irq0, irq1, irq2} !== 3'b000) begin
      nbad++;
      $display("FAIL irq_idle: got %b want 000", {irq0, irq1, irq2});
    end
    @(negedge clk);
    in_port[0] = 1'b1;
    wait_cyc(10);
    ncmp++;
    if ({irq0, irq1, irq2} !== 3'b101) begin
      nbad++;
      $display("FAIL irq_rise: got %b want 101", {irq0, irq1, irq2});
    end
    issue(2'd3, 1, 0, 1, "irq_ec");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    wr(2'd3, 32'h1);
    ncmp++;
    if ({irq0, irq1, irq2} !== 3'b000) begin
      nbad++;
      $display("FAIL irq_clr: got %b want 000", {irq0, irq1, irq2});
    end
    issue(2'd3, 0, 0, 0, "irq_ec_clr");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
  endtask

  task automatic test_set_wins;
    @(negedge clk);
    in_port[0] = 1'b0;
    wait_cyc(10);
    wr(2'd3, 32'h7);
    @(negedge clk);
    in_port[0] = 1'b1;
    wait_cyc(4);
    // this write lands on the edge where stable[0] rises
    wr(2'd3, 32'h1);
    ncmp++;
    if ({irq0, irq1, irq2} !== 3'b101) begin
      nbad++;
      $display("FAIL setwin_irq: got %b want 101", {irq0, irq1, irq2});
    end
    issue(2'd3, 1, 0, 1, "setwin_ec");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
  endtask

  task automatic test_edge_type;
    @(negedge clk);
    in_port[0] = 1'b0;
    wait_cyc(10);
    wr(2'd3, 32'h7);
    @(negedge clk);
    in_port[0] = 1'b1;
    wait_cyc(10);
    issue(2'd3, 1, 0, 1, "edge_press");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    wr(2'd3, 32'h7);
    @(negedge clk);
    in_port[0] = 1'b0;
    wait_cyc(10);
    issue(2'd3, 0, 1, 1, "edge_release");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    ncmp++;
    if ({irq0, irq1, irq2} !== 3'b011) begin
      nbad++;
      $display("FAIL edge_irq: got %b want 011", {irq0, irq1, irq2});
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_port = 3'h7;
    address = 2'd0;
    wait_cyc(3);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{$sformatf("rmid_in_rst%0d", k), 0, 0, 0});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      ncmp++;
      if ({rd0, rd1, rd2, irq0, irq1, irq2} !==
          {e.e0, e.e1, e.e2, 3'b000}) begin
        nbad++;
        $display("FAIL %s: got %h/%h/%h irq %b want %h/%h/%h irq 000",
                 e.nm, rd0, rd1, rd2, {irq0, irq1, irq2},
                 e.e0, e.e1, e.e2);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      logic [31:0] v;
      v = (k == 7) ? 32'd7 : 32'd0;
      sb.push_back('{$sformatf("rmid_edge%0d", k), v, v, v});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      ncmp++;
      if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
        nbad++;
        $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
                 e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
      end
    end
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    issue(2'd3, 7, 0, 7, "rmid_ec");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    issue(2'd2, 0, 0, 0, "rmid_mask");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    issue(2'd0, 7, 7, 7, "wr0_ignored");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    issue(2'd1, 0, 0, 0, "addr1_zero");
    e = sb.pop_front();
    ncmp++;
    if ({rd0, rd1, rd2} !== {e.e0, e.e1, e.e2}) begin
      nbad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h",
               e.nm, rd0, rd1, rd2, e.e0, e.e1, e.e2);
    end
    ncmp++;
    if ({irq0, irq1, irq2} !== 3'b000) begin
      nbad++;
      $display("FAIL rmid_irq: got %b want 000", {irq0, irq1, irq2});
    end
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_glitch;
    test_irq;
    test_set_wins;
    test_edge_type;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/blinky_button_pio.md
BLINKY_BUTTON_PIO -- requirements
Module: blinky_button_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 3: number of input bits, legal range 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a new level, legal range >=1.
REQ-003 SHALL have parameter EDGE_TYPE, default 0: captured edge type; 0 rising, 1 falling, 2 any.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port address  in  2  Avalon-MM register word select.
REQ-007 SHALL have port chipselect  in  1  Avalon-MM select.
REQ-008 SHALL have port write_n  in  1  Avalon-MM write strobe, active low.
REQ-009 SHALL have port writedata  in  32  Avalon-MM write data.
REQ-010 SHALL have port readdata  out  32  Avalon-MM read data, registered.
REQ-011 SHALL have port in_port  in  WIDTH  asynchronous raw button inputs.
REQ-012 SHALL have port irq  out  1  level interrupt request, active high.

Function
REQ-013 SHALL pass in_port through a two-flop synchronizer (sync1, sync2) per bit.
REQ-014 SHALL keep, per bit, a debounced level "stable" and a counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-015 SHALL clear a bit's counter in any cycle where sync2 equals stable.
REQ-016 SHALL increment the counter in any cycle where sync2 differs from stable and the counter is below DEBOUNCE_CYCLES-1.
REQ-017 SHALL load stable from sync2 and clear the counter in any cycle where sync2 differs from stable and the counter equals DEBOUNCE_CYCLES-1.
REQ-018 SHALL therefore update stable exactly DEBOUNCE_CYCLES+1 edges after the first edge that samples a held in_port change.
REQ-019 SHALL restart the count from zero on any glitch shorter than the debounce window; stable does not change.
REQ-020 SHALL set edgecapture[i] in the cycle stable[i] changes in the direction selected by EDGE_TYPE.
REQ-021 SHALL clear edgecapture[i] on a write (chipselect=1, write_n=0) to address 3 with writedata[i]=1.
REQ-022 SHALL let a set win over a clear when both occur on the same bit in the same cycle.
REQ-023 SHALL load irqmask[WIDTH-1:0] from writedata on a write to address 2.
REQ-024 SHALL ignore writes to addresses 0 and 1.
REQ-025 SHALL drive irq = OR of (edgecapture AND irqmask), from registered state only, with no added cycle.
REQ-026 SHALL register readdata on every clock, independent of chipselect, giving one cycle of read latency.
REQ-027 SHALL select readdata by address: 0 = stable, 1 = zero, 2 = irqmask, 3 = edgecapture.
REQ-028 SHALL zero-extend readdata above WIDTH.

Reset
REQ-029 SHALL, while reset=1, clear sync1, sync2, stable, counters, edgecapture, irqmask and readdata to 0; irq is then 0.
REQ-030 SHALL abandon any debounce in progress on reset mid-count; counting restarts from 0 after release.
REQ-031 SHALL treat an input held high through reset as a 0->1 transition after release: stable rises after the debounce delay, and rising edge capture occurs when EDGE_TYPE is 0 or 2.

Verification
REQ-032 SHALL cover: DEBOUNCE_CYCLES=4, in_port[0] 0->1 held -> stable[0]=1 exactly 5 edges after the first sampling edge; read of address 0 returns 0x1 one cycle later.
REQ-033 SHALL cover: 3-cycle pulse on in_port[1] with DEBOUNCE_CYCLES=4 -> stable, edgecapture and irq all remain 0.
REQ-034 SHALL cover: irqmask=0x1 and a debounced rise on bit 0 -> edgecapture=0x1 and irq=1; write 0x1 to address 3 -> edgecapture=0 and irq=0 next cycle.
REQ-035 SHALL cover: clear write to address 3 in the same cycle bit 0 is set -> edgecapture[0]=1 remains.
REQ-036 SHALL cover: EDGE_TYPE=1, press then release -> only the 1->0 transition is captured; with EDGE_TYPE=2, both transitions are captured.
REQ-037 SHALL cover: reset asserted mid-debounce with in_port held at 0x7 -> all outputs 0 during reset; stable=0x7 DEBOUNCE_CYCLES+1 edges after release; address 1 always reads 0.
